// File: rtl/rv32i_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle controller: opcodes, ALU codes, FSM states, trap causes.
package rv32i_ctrl_pkg;

  localparam int unsigned ALU_CODE_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 5'b00001;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 5'b00010;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 5'b00011;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 5'b00100;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 5'b00101;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 5'b00110;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 5'b00111;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 5'b01000;
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 5'b01001;
  localparam logic [ALU_CODE_W-1:0] ALU_LB   = 5'b01010;
  localparam logic [ALU_CODE_W-1:0] ALU_LH   = 5'b01011;
  localparam logic [ALU_CODE_W-1:0] ALU_LW   = 5'b01100;
  localparam logic [ALU_CODE_W-1:0] ALU_LBU  = 5'b01101;
  localparam logic [ALU_CODE_W-1:0] ALU_LHU  = 5'b01110;
  localparam logic [ALU_CODE_W-1:0] ALU_SB   = 5'b01111;
  localparam logic [ALU_CODE_W-1:0] ALU_SH   = 5'b10000;
  localparam logic [ALU_CODE_W-1:0] ALU_SW   = 5'b10001;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

endpackage

// File: rtl/rv32i_alu_decode.sv
// IR fields -> ALU operation, immediate-operand select and illegal flag.
// Branch opcodes are legal only when RV32I_MC_BRANCH_EN is defined.
module rv32i_alu_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_b5,
  output logic [ALU_CODE_W-1:0] alu_code,
  output logic                  imm_sel,
  output logic                  illegal
);

  always_comb begin
    alu_code = ALU_ADD;
    imm_sel  = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        imm_sel = (opcode == OP_I);
        case (funct3)
          // bit 30 means sub only for the register form; addi is always add
          3'b000:  alu_code = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_code = ALU_SLL;
          3'b010:  alu_code = ALU_SLT;
          3'b011:  alu_code = ALU_SLTU;
          3'b100:  alu_code = ALU_XOR;
          3'b101:  alu_code = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_code = ALU_OR;
          default: alu_code = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        imm_sel = 1'b1;
        case (funct3)
          3'b000:  alu_code = ALU_LB;
          3'b001:  alu_code = ALU_LH;
          3'b010:  alu_code = ALU_LW;
          3'b100:  alu_code = ALU_LBU;
          3'b101:  alu_code = ALU_LHU;
          default: illegal  = 1'b1;
        endcase
      end
      OP_STORE: begin
        imm_sel = 1'b1;
        case (funct3)
          3'b000:  alu_code = ALU_SB;
          3'b001:  alu_code = ALU_SH;
          3'b010:  alu_code = ALU_SW;
          default: illegal  = 1'b1;
        endcase
      end
`ifdef RV32I_MC_BRANCH_EN
      OP_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_code = ALU_SUB;
          3'b100, 3'b101: alu_code = ALU_SLT;
          3'b110, 3'b111: alu_code = ALU_SLTU;
          default:        illegal  = 1'b1;
        endcase
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_controller.sv
// Multi-cycle RV32I control FSM with memory wait/timeout handling, traps and retire counter.
// Define RV32I_MC_BRANCH_EN to enable conditional branches (opcode 1100011).
module rv32i_mc_controller
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned ALU_W       = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             alu_zero,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             MemRW,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             RegWE,
  output logic [ALU_W-1:0] ALU_control,
  output logic             Imm_mux_SEL,
  output logic             WB_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t                  state;
  logic [6:0]              ir_op;
  logic [4:0]              ir_rd;
  logic [2:0]              ir_f3;
  logic                    ir_b30;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    pc_we_q;
  logic [ALU_CODE_W-1:0]   dec_code;
  logic                    dec_imm;
  logic                    dec_illegal;
  logic                    is_load;
  logic                    is_store;
  logic                    is_branch;
  logic                    fetch_done_c;
  logic                    mem_done_c;
  logic                    store_done_c;
  logic                    retire_c;
  logic                    unused_instr;

  rv32i_alu_decode u_alu_decode (
    .opcode    (ir_op),
    .funct3    (ir_f3),
    .funct7_b5 (ir_b30),
    .alu_code  (dec_code),
    .imm_sel   (dec_imm),
    .illegal   (dec_illegal)
  );

  // Only the fields the controller decodes are kept from the fetched word
  assign unused_instr = ^{instr[31], instr[29:15]};

  assign is_load   = (ir_op == OP_LOAD);
  assign is_store  = (ir_op == OP_STORE);
  assign is_branch = (ir_op == OP_BRANCH);

  // Ready only counts while the matching request is up
  assign fetch_done_c = imem_req & imem_ready;
  assign mem_done_c   = dmem_req & dmem_ready;
  assign store_done_c = mem_done_c & MemRW;

  assign ir_we    = fetch_done_c;
  assign pc_we    = pc_we_q | store_done_c;
  assign retire_c = (state == WB) | ((state == EXEC) & is_branch) | store_done_c;

`ifdef RV32I_MC_BRANCH_EN
  logic taken_c;
  // Ordered compares see ALU result 1 (non-zero) when less-than
  assign taken_c = (ir_f3[2] ? ~alu_zero : alu_zero) ^ ir_f3[0];
  assign pc_sel  = (state == EXEC) & pc_we_q & taken_c;
`else
  logic unused_branch;
  assign unused_branch = alu_zero;
  assign pc_sel        = 1'b0;
`endif

  // State and registered outputs: each transition loads the outputs of the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      ir_op       <= '0;
      ir_rd       <= '0;
      ir_f3       <= '0;
      ir_b30      <= 1'b0;
      wait_cnt    <= '0;
      pc_we_q     <= 1'b0;
      imem_req    <= 1'b0;
      dmem_req    <= 1'b0;
      MemRW       <= 1'b0;
      RegWE       <= 1'b0;
      ALU_control <= '0;
      Imm_mux_SEL <= 1'b0;
      WB_sel      <= 1'b0;
      trap        <= 1'b0;
      trap_cause  <= CAUSE_NONE;
      retired     <= '0;
    end else begin
      imem_req    <= 1'b0;
      dmem_req    <= 1'b0;
      MemRW       <= 1'b0;
      RegWE       <= 1'b0;
      ALU_control <= '0;
      Imm_mux_SEL <= 1'b0;
      WB_sel      <= 1'b0;
      pc_we_q     <= 1'b0;

      if (retire_c) retired <= retired + CNT_W'(1);

      case (state)
        FETCH: begin
          if (fetch_done_c) begin
            ir_op  <= instr[6:0];
            ir_rd  <= instr[11:7];
            ir_f3  <= instr[14:12];
            ir_b30 <= instr[30];
            state  <= DECODE;
          end else if (!imem_req) begin
            // first cycle out of reset: raise the request, nothing to wait on yet
            imem_req <= 1'b1;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_IMEM_TO;
          end else begin
            imem_req <= 1'b1;
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        DECODE: begin
          if (dec_illegal) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
          end else begin
            state       <= EXEC;
            ALU_control <= ALU_W'(dec_code);
            Imm_mux_SEL <= dec_imm;
            pc_we_q     <= is_branch;
          end
        end

        EXEC: begin
          if (is_branch) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            wait_cnt <= '0;
          end else if (is_load || is_store) begin
            state    <= MEM;
            dmem_req <= 1'b1;
            MemRW    <= is_store;
            wait_cnt <= '0;
          end else begin
            state   <= WB;
            RegWE   <= (ir_rd != 5'd0);
            pc_we_q <= 1'b1;
          end
        end

        MEM: begin
          if (mem_done_c) begin
            if (MemRW) begin
              state    <= FETCH;
              imem_req <= 1'b1;
              wait_cnt <= '0;
            end else begin
              state   <= WB;
              RegWE   <= (ir_rd != 5'd0);
              WB_sel  <= 1'b1;
              pc_we_q <= 1'b1;
            end
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_DMEM_TO;
          end else begin
            dmem_req <= 1'b1;
            MemRW    <= MemRW;
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        WB: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end

        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// Directed self-checking bench for rv32i_mc_controller; branch expectations follow RV32I_MC_BRANCH_EN.
module tb_rv32i_mc_controller;

  localparam int unsigned ALU_W       = 5;
  localparam int unsigned CNT_W       = 32;
  localparam int unsigned MEM_TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr;
  logic             imem_ready;
  logic             dmem_ready;
  logic             alu_zero;
  logic             imem_req;
  logic             dmem_req;
  logic             MemRW;
  logic             ir_we;
  logic             pc_we;
  logic             pc_sel;
  logic             RegWE;
  logic [ALU_W-1:0] ALU_control;
  logic             Imm_mux_SEL;
  logic             WB_sel;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] retired;

  // {imem_req, dmem_req, MemRW, ir_we, pc_we, pc_sel, RegWE, Imm_mux_SEL, WB_sel, trap}
  logic [9:0] ctl;
  assign ctl = {imem_req, dmem_req, MemRW, ir_we, pc_we, pc_sel, RegWE, Imm_mux_SEL, WB_sel, trap};

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rv32i_mc_controller #(
    .ALU_W       (ALU_W),
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .alu_zero    (alu_zero),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .MemRW       (MemRW),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .RegWE       (RegWE),
    .ALU_control (ALU_control),
    .Imm_mux_SEL (Imm_mux_SEL),
    .WB_sel      (WB_sel),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .retired     (retired)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the idle cycle right after reset is released
  task automatic do_reset();
    rst        = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    alu_zero   = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    tests_run++;
    if (ctl !== 10'b0) begin
      tests_failed++; $display("FAIL reset_ctl: got %b exp %b", ctl, 10'b0);
    end
    tests_run++;
    if (ALU_control !== 5'b00000 || trap_cause !== 2'b00) begin
      tests_failed++; $display("FAIL reset_alu_cause: got %b/%b exp 00000/00", ALU_control, trap_cause);
    end
    tests_run++;
    if (retired !== 32'd0) begin
      tests_failed++; $display("FAIL reset_retired: got %0d exp 0", retired);
    end
    rst        = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    next_cycle();
    #1;
    tests_run++;
    if (ctl !== 10'b1000000000) begin
      tests_failed++; $display("FAIL reset_release_req: got %b exp %b", ctl, 10'b1000000000);
    end
  endtask

  task automatic test_add();
    logic [9:0] exp_ctl [6];
    exp_ctl = '{10'b0, 10'b1001000000, 10'b0, 10'b0, 10'b0000101000, 10'b1000000000};
    do_reset();
    instr = 32'h002081B3;
    for (int c = 0; c < 6; c++) begin
      imem_ready = (c <= 1);
      dmem_ready = 1'b1;
      #1;
      tests_run++;
      if (ctl !== exp_ctl[c]) begin
        tests_failed++; $display("FAIL add_ctl c%0d: got %b exp %b", c, ctl, exp_ctl[c]);
      end
      if (c == 3) begin
        tests_run++;
        if (ALU_control !== 5'b00000) begin
          tests_failed++; $display("FAIL add_alu: got %b exp 00000", ALU_control);
        end
      end
      if (c == 5) begin
        tests_run++;
        if (retired !== 32'd1) begin
          tests_failed++; $display("FAIL add_retired: got %0d exp 1", retired);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_load_wait();
    logic [9:0] exp_ctl [10];
    exp_ctl = '{10'b0, 10'b1001000000, 10'b0, 10'b0000000100, 10'b0100000000,
                10'b0100000000, 10'b0100000000, 10'b0100000000, 10'b0000101010, 10'b1000000000};
    do_reset();
    instr = 32'h0040A283;
    for (int c = 0; c < 10; c++) begin
      imem_ready = (c == 1);
      dmem_ready = (c == 7);
      #1;
      tests_run++;
      if (ctl !== exp_ctl[c]) begin
        tests_failed++; $display("FAIL lw_ctl c%0d: got %b exp %b", c, ctl, exp_ctl[c]);
      end
      if (c == 3) begin
        tests_run++;
        if (ALU_control !== 5'b01100) begin
          tests_failed++; $display("FAIL lw_alu: got %b exp 01100", ALU_control);
        end
      end
      if (c == 9) begin
        tests_run++;
        if (retired !== 32'd1) begin
          tests_failed++; $display("FAIL lw_retired: got %0d exp 1", retired);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_store();
    logic [9:0] exp_ctl [7];
    exp_ctl = '{10'b0, 10'b1001000000, 10'b0, 10'b0000000100, 10'b0110000000,
                10'b0110100000, 10'b1000000000};
    do_reset();
    instr = 32'h0020A423;
    for (int c = 0; c < 7; c++) begin
      imem_ready = (c == 1);
      dmem_ready = (c == 5);
      #1;
      tests_run++;
      if (ctl !== exp_ctl[c]) begin
        tests_failed++; $display("FAIL sw_ctl c%0d: got %b exp %b", c, ctl, exp_ctl[c]);
      end
      if (c == 3) begin
        tests_run++;
        if (ALU_control !== 5'b10001) begin
          tests_failed++; $display("FAIL sw_alu: got %b exp 10001", ALU_control);
        end
      end
      if (c == 6) begin
        tests_run++;
        if (retired !== 32'd1) begin
          tests_failed++; $display("FAIL sw_retired: got %0d exp 1", retired);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    logic [9:0] exp_ctl [7];
    exp_ctl = '{10'b0, 10'b1001000000, 10'b0, 10'b0000000001, 10'b0000000001,
                10'b0000000001, 10'b0000000001};
    do_reset();
    instr = 32'h0000007F;
    for (int c = 0; c < 7; c++) begin
      imem_ready = (c == 1) || (c >= 3);
      dmem_ready = (c >= 3);
      #1;
      tests_run++;
      if (ctl !== exp_ctl[c]) begin
        tests_failed++; $display("FAIL illegal_ctl c%0d: got %b exp %b", c, ctl, exp_ctl[c]);
      end
      if (c == 6) begin
        tests_run++;
        if (trap_cause !== 2'b01 || retired !== 32'd0) begin
          tests_failed++; $display("FAIL illegal_cause: got %b/%0d exp 01/0", trap_cause, retired);
        end
      end
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    #1;
    tests_run++;
    if (ctl !== 10'b0 || trap_cause !== 2'b00) begin
      tests_failed++; $display("FAIL illegal_rst_clear: got %b/%b exp 0/00", ctl, trap_cause);
    end
    rst        = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    next_cycle();
    #1;
    tests_run++;
    if (ctl !== 10'b1000000000) begin
      tests_failed++; $display("FAIL illegal_rst_req: got %b exp %b", ctl, 10'b1000000000);
    end
  endtask

  task automatic test_alu_codes();
    logic [31:0] v_instr [11];
    logic [4:0]  v_alu   [11];
    logic        v_imm   [11];
    logic        v_trap  [11];
    v_instr = '{32'h402081B3, 32'h4020D1B3, 32'h0020D1B3, 32'h0020F1B3, 32'h40008193,
                32'h4030D193, 32'h0030B193, 32'h0000C283, 32'h00209423, 32'h0000B283,
                32'h00208463};
    v_alu   = '{5'b00001, 5'b00111, 5'b00110, 5'b01001, 5'b00000,
                5'b00111, 5'b00100, 5'b01101, 5'b10000, 5'b00000, 5'b00001};
    v_imm   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef RV32I_MC_BRANCH_EN
    v_trap  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    v_trap  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 11; i++) begin
      do_reset();
      instr = v_instr[i];
      next_cycle();
      imem_ready = 1'b1;
      next_cycle();
      imem_ready = 1'b0;
      next_cycle();
      #1;
      tests_run++;
      if (trap !== v_trap[i]) begin
        tests_failed++; $display("FAIL decode_trap %h: got %b exp %b", v_instr[i], trap, v_trap[i]);
      end else if (v_trap[i]) begin
        tests_run++;
        if (trap_cause !== 2'b01) begin
          tests_failed++; $display("FAIL decode_cause %h: got %b exp 01", v_instr[i], trap_cause);
        end
      end else begin
        tests_run++;
        if (ALU_control !== v_alu[i] || Imm_mux_SEL !== v_imm[i]) begin
          tests_failed++;
          $display("FAIL decode_alu %h: got %b/%b exp %b/%b", v_instr[i], ALU_control, Imm_mux_SEL,
                   v_alu[i], v_imm[i]);
        end
      end
    end
  endtask

  task automatic test_imem_timeout();
    logic [9:0] exp_v;
    do_reset();
    instr = 32'h002081B3;
    for (int c = 0; c < 18; c++) begin
      imem_ready = 1'b0;
      #1;
      exp_v = (c == 0) ? 10'b0 : 10'b1000000000;
      tests_run++;
      if (ctl !== exp_v) begin
        tests_failed++; $display("FAIL imem_wait c%0d: got %b exp %b", c, ctl, exp_v);
      end
      next_cycle();
    end
    #1;
    tests_run++;
    if (ctl !== 10'b0000000001 || trap_cause !== 2'b10) begin
      tests_failed++; $display("FAIL imem_timeout: got %b/%b exp 0000000001/10", ctl, trap_cause);
    end

    do_reset();
    for (int c = 0; c < 17; c++) begin
      imem_ready = 1'b0;
      next_cycle();
    end
    imem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctl !== 10'b1001000000) begin
      tests_failed++; $display("FAIL imem_late_ready: got %b exp %b", ctl, 10'b1001000000);
    end
    next_cycle();
    imem_ready = 1'b0;
    next_cycle();
    #1;
    tests_run++;
    if (trap !== 1'b0 || ALU_control !== 5'b00000 || imem_req !== 1'b0) begin
      tests_failed++; $display("FAIL imem_late_exec: got trap %b req %b exp 0 0", trap, imem_req);
    end
  endtask

  task automatic test_dmem_timeout();
    do_reset();
    instr = 32'h0040A283;
    for (int c = 0; c < 21; c++) begin
      imem_ready = (c == 1);
      dmem_ready = 1'b0;
      #1;
      if (c == 20) begin
        tests_run++;
        if (ctl !== 10'b0100000000) begin
          tests_failed++; $display("FAIL dmem_last_wait: got %b exp %b", ctl, 10'b0100000000);
        end
      end
      next_cycle();
    end
    #1;
    tests_run++;
    if (ctl !== 10'b0000000001 || trap_cause !== 2'b11) begin
      tests_failed++; $display("FAIL dmem_timeout: got %b/%b exp 0000000001/11", ctl, trap_cause);
    end
  endtask

  task automatic test_branch();
    logic [31:0] b_instr [3];
    logic        b_zero  [3];
    logic [9:0]  b_exec  [3];
    logic [4:0]  b_alu   [3];
    b_instr = '{32'h00208463, 32'h00208463, 32'h0020C463};
    b_zero  = '{1'b1, 1'b0, 1'b0};
    b_alu   = '{5'b00001, 5'b00001, 5'b00011};
`ifdef RV32I_MC_BRANCH_EN
    b_exec  = '{10'b0000110000, 10'b0000100000, 10'b0000110000};
`else
    b_exec  = '{10'b0000000001, 10'b0000000001, 10'b0000000001};
`endif
    for (int i = 0; i < 3; i++) begin
      do_reset();
      instr    = b_instr[i];
      alu_zero = b_zero[i];
      next_cycle();
      imem_ready = 1'b1;
      next_cycle();
      imem_ready = 1'b0;
      next_cycle();
      #1;
      tests_run++;
      if (ctl !== b_exec[i]) begin
        tests_failed++; $display("FAIL branch_exec %0d: got %b exp %b", i, ctl, b_exec[i]);
      end
`ifdef RV32I_MC_BRANCH_EN
      tests_run++;
      if (ALU_control !== b_alu[i]) begin
        tests_failed++; $display("FAIL branch_alu %0d: got %b exp %b", i, ALU_control, b_alu[i]);
      end
      next_cycle();
      #1;
      tests_run++;
      if (ctl !== 10'b1000000000 || retired !== 32'd1) begin
        tests_failed++; $display("FAIL branch_next %0d: got %b/%0d exp 1000000000/1", i, ctl, retired);
      end
`else
      tests_run++;
      if (trap_cause !== 2'b01 || b_alu[i] === 5'bxxxxx) begin
        tests_failed++; $display("FAIL branch_illegal %0d: got %b exp 01", i, trap_cause);
      end
`endif
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    instr = 32'h00208033;
    next_cycle();
    imem_ready = 1'b1;
    next_cycle();
    imem_ready = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    tests_run++;
    if (ctl !== 10'b0000100000) begin
      tests_failed++; $display("FAIL rd0_wb: got %b exp %b", ctl, 10'b0000100000);
    end
    next_cycle();
    #1;
    tests_run++;
    if (retired !== 32'd1) begin
      tests_failed++; $display("FAIL rd0_retired: got %0d exp 1", retired);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [3];
    logic [9:0]  exp_v;
    prog = '{32'h002081B3, 32'h40008193, 32'h0020F1B3};
    do_reset();
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 4; p++) begin
        instr      = prog[i];
        imem_ready = (p == 0);
        #1;
        case (p)
          0:       exp_v = 10'b1001000000;
          1:       exp_v = 10'b0;
          2:       exp_v = (i == 1) ? 10'b0000000100 : 10'b0;
          default: exp_v = 10'b0000101000;
        endcase
        tests_run++;
        if (ctl !== exp_v) begin
          tests_failed++; $display("FAIL b2b_ctl i%0d p%0d: got %b exp %b", i, p, ctl, exp_v);
        end
        next_cycle();
      end
    end
    imem_ready = 1'b0;
    #1;
    tests_run++;
    if (retired !== 32'd3 || ctl !== 10'b1000000000) begin
      tests_failed++; $display("FAIL b2b_retired: got %0d/%b exp 3/1000000000", retired, ctl);
    end
  endtask

  initial begin
    rst        = 1'b1;
    instr      = 32'h0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    alu_zero   = 1'b0;
    test_reset();
    test_add();
    test_load_wait();
    test_store();
    test_illegal();
    test_alu_codes();
    test_imem_timeout();
    test_dmem_timeout();
    test_branch();
    test_rd_zero();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
